// File: rtl/mem_arbiter_if.sv
// Unified memory port between mem_arbiter (master) and the memory model (slave).
// Handshake: a request transfers on a rising edge where o_mem_req & i_mem_ready;
// the single response for it arrives later as a one-cycle i_mem_valid with i_mem_rdata.
interface mem_arbiter_if;
  logic        o_mem_req;
  logic        o_mem_wen;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_ready;
  logic        i_mem_valid;
  logic [31:0] i_mem_rdata;

  modport master (
    output o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask,
    input  i_mem_ready, i_mem_valid, i_mem_rdata
  );

  modport slave (
    input  o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask,
    output i_mem_ready, i_mem_valid, i_mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch vs load/store arbiter onto one handshaked memory port, one access in flight.
// Optional macro MEM_ARB_STARVE_GUARD_EN: force a fetch grant after STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_if_req,
  input  logic [31:0]  i_if_addr,
  output logic         o_if_done,
  output logic [31:0]  o_if_rdata,
  input  logic         i_d_ren,
  input  logic         i_d_wen,
  input  logic [31:0]  i_d_addr,
  input  logic [31:0]  i_d_wdata,
  input  logic [3:0]   i_d_mask,
  output logic         o_d_done,
  output logic [31:0]  o_d_rdata,
  output logic         o_d_err,
  output logic         o_busy,
  output logic [1:0]   o_state,
  mem_arbiter_if.master mem
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int CW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;

  state_t      state, state_next;
  logic        owner_d;
  logic        lat_wen;
  logic        lat_err;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_mask;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;

  logic d_req;
  logic illegal;
  logic force_f;
  logic grant_d;
  logic grant_f;

  assign d_req   = i_d_ren | i_d_wen;
  assign illegal = i_d_ren & i_d_wen;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [CW-1:0] starve_cnt;

  // Counts data grants that overtook a waiting fetch; reaching the limit hands the next grant to fetch.
  assign force_f = i_if_req && (starve_cnt == CW'(STARVE_LIMIT));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (!i_if_req || grant_f) begin
        starve_cnt <= '0;
      end else if (grant_d) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  logic [CW-1:0] unused_starve_limit;
  assign unused_starve_limit = CW'(STARVE_LIMIT);
  assign force_f = 1'b0;
`endif

  always_comb begin
    state_next = state;
    grant_d    = 1'b0;
    grant_f    = 1'b0;
    case (state)
      S_IDLE: begin
        if (d_req && !force_f) begin
          grant_d    = 1'b1;
          state_next = illegal ? S_RESP : S_ISSUE;
        end else if (i_if_req) begin
          grant_f    = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: if (mem.i_mem_ready) state_next = S_WAIT;
      S_WAIT:  if (mem.i_mem_valid) state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      owner_d    <= 1'b0;
      lat_wen    <= 1'b0;
      lat_err    <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_mask   <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state <= state_next;
      if (grant_d || grant_f) begin
        owner_d   <= grant_d;
        lat_addr  <= (grant_d ? i_d_addr : i_if_addr) & 32'hFFFF_FFFC;
        lat_wen   <= grant_d & i_d_wen & ~i_d_ren;
        lat_wdata <= grant_d ? i_d_wdata : 32'h0;
        lat_mask  <= grant_d ? i_d_mask : 4'hF;
        lat_err   <= grant_d & illegal;
      end
      // Write responses carry no data, so both rdata registers keep their last load.
      if (state == S_WAIT && mem.i_mem_valid && !lat_wen) begin
        if (owner_d) d_rdata_q  <= mem.i_mem_rdata;
        else         if_rdata_q <= mem.i_mem_rdata;
      end
    end
  end

  assign o_busy          = (state != S_IDLE);
  assign o_state         = state;
  assign o_if_done       = (state == S_RESP) && !owner_d;
  assign o_d_done        = (state == S_RESP) && owner_d;
  assign o_d_err         = (state == S_RESP) && owner_d && lat_err;
  assign o_if_rdata      = if_rdata_q;
  assign o_d_rdata       = d_rdata_q;
  assign mem.o_mem_req   = (state == S_ISSUE);
  assign mem.o_mem_wen   = lat_wen;
  assign mem.o_mem_addr  = lat_addr;
  assign mem.o_mem_wdata = lat_wdata;
  assign mem.o_mem_mask  = lat_mask;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: cycle-accurate scenarios against a delay-configurable memory model.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_ren = 1'b0;
  logic        d_wen = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_mask = '0;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        busy;
  logic [1:0]  state;

  mem_arbiter_if mem();

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_if_req   (if_req),
    .i_if_addr  (if_addr),
    .o_if_done  (if_done),
    .o_if_rdata (if_rdata),
    .i_d_ren    (d_ren),
    .i_d_wen    (d_wen),
    .i_d_addr   (d_addr),
    .i_d_wdata  (d_wdata),
    .i_d_mask   (d_mask),
    .o_d_done   (d_done),
    .o_d_rdata  (d_rdata),
    .o_d_err    (d_err),
    .o_busy     (busy),
    .o_state    (state),
    .mem        (mem)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // Memory model knobs, set by the scenario tasks.
  int          rdy_wait = 0;
  int          vld_wait = 0;
  logic [31:0] rd_value = '0;

  // Memory model: decides ready/valid at each falling edge for the next rising edge.
  initial begin
    int   rcnt;
    int   vcnt;
    logic in_wait;
    rcnt = 0; vcnt = 0; in_wait = 1'b0;
    mem.i_mem_ready = 1'b0;
    mem.i_mem_valid = 1'b0;
    mem.i_mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem.i_mem_ready = 1'b0;
      mem.i_mem_valid = 1'b0;
      if (in_wait) begin
        if (vcnt == vld_wait) begin
          mem.i_mem_valid = 1'b1;
          mem.i_mem_rdata = rd_value;
          in_wait = 1'b0;
        end else begin
          vcnt++;
        end
      end else if (mem.o_mem_req === 1'b1) begin
        if (rcnt == rdy_wait) begin
          mem.i_mem_ready = 1'b1;
          in_wait = 1'b1;
          vcnt = 0;
          rcnt = 0;
        end else begin
          rcnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({if_done, d_done, d_err, busy, state} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 000000", {if_done, d_done, d_err, busy, state});
    end
    checks++;
    if ({if_rdata, d_rdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h required 0", {if_rdata, d_rdata});
    end
    checks++;
    if ({mem.o_mem_req, mem.o_mem_wen, mem.o_mem_addr, mem.o_mem_wdata, mem.o_mem_mask} !== 70'h0) begin
      errors++;
      $display("FAIL reset_mem: got %h required 0",
               {mem.o_mem_req, mem.o_mem_wen, mem.o_mem_addr, mem.o_mem_wdata, mem.o_mem_mask});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch_read();
    rdy_wait = 0; vld_wait = 0;
    rd_value = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    if_req = 1'b1; if_addr = 32'h100;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL fetch_c0_busy: got %b required 0", busy); end
    tick();
    checks++;
    if ({mem.o_mem_req, mem.o_mem_wen, mem.o_mem_addr, mem.o_mem_mask} !== {1'b1, 1'b0, 32'h100, 4'hF}) begin
      errors++;
      $display("FAIL fetch_c1_issue: req %b wen %b addr %h mask %h required 1 0 00000100 f",
               mem.o_mem_req, mem.o_mem_wen, mem.o_mem_addr, mem.o_mem_mask);
    end
    tick();
    checks++;
    if ({state, mem.o_mem_req} !== {2'd2, 1'b0}) begin
      errors++;
      $display("FAIL fetch_c2_wait: state %0d req %b required 2 0", state, mem.o_mem_req);
    end
    tick();
    begin
      logic [31:0] exp;
      exp = exp_q.pop_front();
      checks++;
      if ({if_done, d_done, if_rdata} !== {1'b1, 1'b0, exp}) begin
        errors++;
        $display("FAIL fetch_c3_done: if_done %b d_done %b rdata %h required 1 0 %h", if_done, d_done, if_rdata, exp);
      end
    end
    if_req = 1'b0;
    tick();
    checks++;
    if ({if_done, busy, if_rdata} !== {1'b0, 1'b0, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL fetch_c4_idle: done %b busy %b rdata %h required 0 0 deadbeef", if_done, busy, if_rdata);
    end
  endtask

  task automatic test_simultaneous();
    rd_value = 32'hA5A5_0001;
    exp_q.push_back(32'hA5A5_0001);
    if_req = 1'b1; if_addr = 32'h200;
    d_ren = 1'b1; d_addr = 32'h1003; d_mask = 4'b1000;
    tick();
    checks++;
    if ({mem.o_mem_req, mem.o_mem_addr, mem.o_mem_mask} !== {1'b1, 32'h1000, 4'b1000}) begin
      errors++;
      $display("FAIL simul_c1_data_first: req %b addr %h mask %h required 1 00001000 8",
               mem.o_mem_req, mem.o_mem_addr, mem.o_mem_mask);
    end
    tick();
    tick();
    begin
      logic [31:0] exp;
      exp = exp_q.pop_front();
      checks++;
      if ({d_done, if_done, d_err, d_rdata} !== {1'b1, 1'b0, 1'b0, exp}) begin
        errors++;
        $display("FAIL simul_c3_data_done: d_done %b if_done %b err %b rdata %h required 1 0 0 %h",
                 d_done, if_done, d_err, d_rdata, exp);
      end
    end
    d_ren = 1'b0;
    tick();
    checks++;
    if ({state, mem.o_mem_req} !== {2'd0, 1'b0}) begin
      errors++;
      $display("FAIL simul_c4_idle: state %0d req %b required 0 0", state, mem.o_mem_req);
    end
    rd_value = 32'h0F0F_1234;
    exp_q.push_back(32'h0F0F_1234);
    tick();
    checks++;
    if ({mem.o_mem_req, mem.o_mem_addr, mem.o_mem_mask} !== {1'b1, 32'h200, 4'hF}) begin
      errors++;
      $display("FAIL simul_c5_fetch_issue: req %b addr %h mask %h required 1 00000200 f",
               mem.o_mem_req, mem.o_mem_addr, mem.o_mem_mask);
    end
    tick();
    tick();
    begin
      logic [31:0] exp;
      exp = exp_q.pop_front();
      checks++;
      if ({if_done, if_rdata, d_rdata} !== {1'b1, exp, 32'hA5A5_0001}) begin
        errors++;
        $display("FAIL simul_c7_fetch_done: done %b if_rdata %h d_rdata %h required 1 %h a5a50001",
                 if_done, if_rdata, d_rdata, exp);
      end
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_write_stall();
    int req_cycles;
    rdy_wait = 3; vld_wait = 2;
    rd_value = 32'hBAD0_BAD0;
    exp_q.push_back(32'hA5A5_0001);
    d_wen = 1'b1; d_addr = 32'h2006; d_wdata = 32'h1122_3344; d_mask = 4'b1100;
    req_cycles = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 2) begin
        d_wen = 1'b0; d_addr = 32'hFFFF_FFFF; d_wdata = '0; d_mask = '0;
      end
      if ({mem.o_mem_req, mem.o_mem_wen, mem.o_mem_addr, mem.o_mem_wdata, mem.o_mem_mask}
          === {1'b1, 1'b1, 32'h2004, 32'h1122_3344, 4'b1100}) req_cycles++;
    end
    checks++;
    if (req_cycles !== 4) begin
      errors++;
      $display("FAIL write_stable_req: got %0d stable cycles required 4", req_cycles);
    end
    tick();
    checks++;
    if ({mem.o_mem_req, state} !== {1'b0, 2'd2}) begin
      errors++;
      $display("FAIL write_c5_wait: req %b state %0d required 0 2", mem.o_mem_req, state);
    end
    tick();
    tick();
    checks++;
    if (d_done !== 1'b0) begin errors++; $display("FAIL write_c7_early: done %b required 0", d_done); end
    tick();
    begin
      logic [31:0] exp;
      exp = exp_q.pop_front();
      checks++;
      if ({d_done, d_err, d_rdata} !== {1'b1, 1'b0, exp}) begin
        errors++;
        $display("FAIL write_c8_done: done %b err %b rdata %h required 1 0 %h", d_done, d_err, d_rdata, exp);
      end
    end
    rdy_wait = 0; vld_wait = 0;
    tick();
  endtask

  task automatic test_illegal();
    int req_seen;
    exp_q.push_back(32'hA5A5_0001);
    d_ren = 1'b1; d_wen = 1'b1; d_addr = 32'h3000; d_mask = 4'hF;
    req_seen = 0;
    tick();
    if (mem.o_mem_req !== 1'b0) req_seen++;
    begin
      logic [31:0] exp;
      exp = exp_q.pop_front();
      checks++;
      if ({d_done, d_err, d_rdata} !== {1'b1, 1'b1, exp}) begin
        errors++;
        $display("FAIL illegal_c1_done_err: done %b err %b rdata %h required 1 1 %h", d_done, d_err, d_rdata, exp);
      end
    end
    d_ren = 1'b0; d_wen = 1'b0;
    tick();
    if (mem.o_mem_req !== 1'b0) req_seen++;
    checks++;
    if ({state, d_done, d_err} !== {2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL illegal_c2_idle: state %0d done %b err %b required 0 0 0", state, d_done, d_err);
    end
    checks++;
    if (req_seen !== 0) begin errors++; $display("FAIL illegal_no_mem_req: got %0d cycles required 0", req_seen); end
  endtask

  task automatic test_reset_in_wait();
    int done_seen;
    rdy_wait = 0; vld_wait = 3;
    rd_value = 32'h0BAD_F00D;
    if_req = 1'b1; if_addr = 32'h400;
    tick();
    tick();
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL rstwait_in_wait: state %0d required 2", state); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({if_done, d_done, d_err, busy, state, mem.o_mem_req, if_rdata, d_rdata} !== 71'h0) begin
      errors++;
      $display("FAIL rstwait_outputs: req %b busy %b state %0d if_rdata %h d_rdata %h required all 0",
               mem.o_mem_req, busy, state, if_rdata, d_rdata);
    end
    if_req = 1'b0;
    tick();
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (if_done !== 1'b0 || d_done !== 1'b0 || busy !== 1'b0) done_seen++;
    end
    checks++;
    if ({done_seen, if_rdata} !== {32'd0, 32'h0}) begin
      errors++;
      $display("FAIL rstwait_late_valid: active cycles %0d if_rdata %h required 0 00000000", done_seen, if_rdata);
    end
    vld_wait = 0;
  endtask

  task automatic test_starvation();
    int got[$];
    int budget;
    exp_q.delete();
`ifdef MEM_ARB_STARVE_GUARD_EN
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1);
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
`else
    for (int i = 0; i < 6; i++) exp_q.push_back(1);
`endif
    rd_value = 32'h5555_AAAA;
    if_req = 1'b1; if_addr = 32'h500;
    d_ren = 1'b1; d_addr = 32'h600; d_mask = 4'hF;
    budget = 0;
    while (got.size() < 6 && budget < 60) begin
      tick();
      budget++;
      if (d_done === 1'b1) got.push_back(1);
      if (if_done === 1'b1) got.push_back(0);
    end
    if_req = 1'b0; d_ren = 1'b0;
    checks++;
    if (got.size() !== 6) begin
      errors++;
      $display("FAIL starve_budget: got %0d completions required 6", got.size());
    end
    for (int i = 0; i < 6; i++) begin
      logic [31:0] exp;
      int act;
      exp = exp_q.pop_front();
      act = (i < got.size()) ? got[i] : -1;
      checks++;
      if (act !== int'(exp)) begin
        errors++;
        $display("FAIL starve_grant_%0d: got %0d required %0d (1=data 0=fetch)", i, act, exp);
      end
    end
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch_read();
    test_simultaneous();
    test_write_stall();
    test_illegal();
    test_reset_in_wait();
    test_starvation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one unified, handshaked memory port between the hart's instruction-fetch path and its load/store path. It sits between the hart and the realistic memory model that replaces the split combinational imem/dmem ports. It accepts one access at a time, holds it until the memory responds, and returns registered read data plus a completion pulse to the owning requester. `o_busy` lets the hart stall while an access is in flight.

## Interface
- `STARVE_LIMIT`, default 4: consecutive data grants allowed while fetch waits; only used when the starvation guard is compiled in (see Configuration).

Ports (clock and reset first):
- `i_clk` in 1: single clock; all state changes on its rising edge.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_if_req` in 1: fetch read request; held until `o_if_done`.
- `i_if_addr` in 32: fetch address.
- `o_if_done` out 1: one-cycle pulse; fetch access complete.
- `o_if_rdata` out 32: fetch data; valid with `o_if_done`, held until the next fetch completion.
- `i_d_ren` in 1: data read request.
- `i_d_wen` in 1: data write request.
- `i_d_addr` in 32: data address.
- `i_d_wdata` in 32: write data, already lane-shifted.
- `i_d_mask` in 4: byte-lane mask.
- `o_d_done` out 1: one-cycle pulse; data access complete.
- `o_d_rdata` out 32: load data; valid with `o_d_done`, held until the next data completion.
- `o_d_err` out 1: pulses with `o_d_done` when the request was illegal.
- `o_mem_req` out 1: memory request valid.
- `o_mem_wen` out 1: 1 for a write, 0 for a read.
- `o_mem_addr` out 32: word-aligned address; bits [1:0] are always 0.
- `o_mem_wdata` out 32: write data.
- `o_mem_mask` out 4: byte mask; 4'b1111 for fetches.
- `i_mem_ready` in 1: memory accepts the request when `o_mem_req & i_mem_ready`.
- `i_mem_valid` in 1: response strobe, for both reads and writes.
- `i_mem_rdata` in 32: read data, qualified by `i_mem_valid`.
- `o_busy` out 1: high whenever the state is not IDLE.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** arbitrate among live requests.
  - Data (`i_d_ren | i_d_wen`) beats fetch (`i_if_req`) unless the starvation guard forces fetch.
  - On a grant, latch owner, address (with [1:0] forced to 0), wen, wdata and mask, then go to ISSUE.
  - With no request, stay in IDLE.
- **Illegal data request:** `i_d_ren & i_d_wen` together is illegal. Grant data, skip memory, go straight to RESP with `o_d_err=1`.
- **ISSUE:** drive `o_mem_req=1` with the latched fields, held stable. On `i_mem_ready`, go to WAIT next cycle.
- **WAIT:** `o_mem_req=0`. On `i_mem_valid`, capture `i_mem_rdata` into the owner's rdata register (writes leave rdata unchanged) and go to RESP.
- **RESP:** pulse the owner's done output (and `o_d_err` if flagged) for one cycle, then return to IDLE. No arbitration happens in RESP.
- **Requests are latched at grant.** Dropping or changing a request after grant has no effect; the access completes and done still pulses.
- **Requester rule:** after seeing done, the requester must deassert its request or present a new one by the next edge.
- **Spurious responses:** `i_mem_valid` in IDLE, ISSUE or RESP is ignored.

## Timing
- Reset value of every output is 0. Reset also sets state=IDLE, clears the rdata registers and clears the starvation counter.
- Reset asserted mid-access drops `o_mem_req` immediately. The in-flight response is discarded and no done pulse is produced.
- All outputs are registered; none depends combinationally on inputs.
- **Zero-wait memory** (ready in the ISSUE cycle, valid on the first WAIT cycle):
  - Request seen in IDLE at cycle 0.
  - `o_mem_req` high at cycle 1.
  - WAIT at cycle 2.
  - Done and rdata at cycle 3.
  - Next arbitration at cycle 4.
  - Throughput is one access per 4 cycles.
- **Illegal request:** done/err at cycle 1, IDLE at cycle 2.
- Each cycle of `i_mem_ready` or `i_mem_valid` delay adds exactly one cycle.

## Configuration
- **`MEM_ARB_STARVE_GUARD_EN` defined:**
  - A 3-bit-minimum counter increments on each data grant made while `i_if_req` is high.
  - It clears on a fetch grant, and on any arbitration where `i_if_req` is low.
  - When counter == `STARVE_LIMIT` and fetch is requesting, the next grant goes to fetch.
- **Undefined:** strict data priority; fetch may starve indefinitely. The counter and `STARVE_LIMIT` are unused.

## Test plan
- **Fetch read:** `i_if_req`=1, addr 0x100, zero-wait memory returning 0xDEADBEEF.
  - `o_mem_req` at cycle 1 with addr 0x100 and mask 4'hF.
  - `o_if_done` and `o_if_rdata`=0xDEADBEEF at cycle 3.
- **Simultaneous requests:** fetch 0x200 and data read 0x1003 (mask 4'b1000) arrive in the same cycle.
  - Data is granted first; `o_mem_addr`=0x1000.
  - Fetch issues at cycle 5 (`o_mem_req` high), after the data access completes at cycle 3 and is re-arbitrated at cycle 4.
- **Write with stall:** write with `i_mem_ready` held low 3 cycles, then `i_mem_valid` delayed 2 cycles.
  - `o_mem_req` is high for 4 cycles with fields stable.
  - `o_d_done` at cycle 8; `o_d_rdata` unchanged.
- **Illegal request:** `i_d_ren`=`i_d_wen`=1.
  - `o_mem_req` never asserts.
  - `o_d_done`=`o_d_err`=1 at cycle 1.
- **Reset in WAIT:** drop `i_rst_n` during WAIT, then return a late `i_mem_valid`.
  - All outputs go to 0 immediately.
  - The late `i_mem_valid` produces no done.
- **Starvation guard:** with guard enabled and `STARVE_LIMIT`=4, hold data and fetch continuously.
  - Grant order is D, D, D, D, F, D…
  - With the macro undefined, fetch is never granted.
